// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef logic [XLEN-1:0] addr_t;

  localparam addr_t PC_INC = 32'd4;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef struct packed {
    addr_t           pc;
    logic [ILEN-1:0] instr;
    logic            err;
  } entry_t;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous instruction queue; clear has priority over pop, and a push
// in the clearing cycle leaves exactly that one entry.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear_i,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  do_push;
  logic                  do_pop;
  entry_t                mem_q [DEPTH];

  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && (clear_i || !full_o);
    do_pop   = pop_i && !empty_o && !clear_i;
    wr_idx   = clear_i ? '0 : wr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = do_push ? DEPTH_LOG2'(1) : '0;
      count_d  = do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: sequential fetch into a small queue with redirect,
// miss drain and fence.i flush. IFETCH_MISALIGN_TRAP_EN enables misaligned-target trapping.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QDEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fence_i,
  output logic        cache_valid,
  input  logic        cache_ready,
  output logic [31:0] cache_addr,
  input  logic [31:0] cache_rdata,
  output logic        cache_flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_err
);

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e state_q, state_d;
  addr_t  pc_q, pc_d;
  addr_t  tgt_q, tgt_d;
  logic   fence_q, fence_d;

  addr_t  redir_tgt;
  addr_t  land_tgt;
  logic   land;
  logic   fifo_clear, fifo_push, fifo_pop;
  logic   fifo_full, fifo_empty;
  entry_t push_entry, head;

  assign redir_tgt   = TRAP_EN ? redirect_pc : {redirect_pc[31:2], 2'b00};
  assign cache_addr  = pc_q;
  assign cache_flush = state_q == S_FLUSH;
  assign out_valid   = !fifo_empty;
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_err     = head.err & TRAP_EN;

  always_comb begin
    unique case (state_q)
      S_RUN:   cache_valid = !fifo_full;
      S_DRAIN: cache_valid = 1'b1;
      default: cache_valid = 1'b0;
    endcase
  end

  // Next-state: redirects clear the queue; "land" restarts fetch at land_tgt.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    tgt_d            = tgt_q;
    fence_d          = fence_q;
    fifo_clear       = 1'b0;
    fifo_push        = 1'b0;
    fifo_pop         = out_valid && out_ready;
    push_entry.pc    = pc_q;
    push_entry.instr = cache_rdata;
    push_entry.err   = 1'b0;
    land             = 1'b0;
    land_tgt         = tgt_q;

    unique case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          fifo_clear = 1'b1;
          if (cache_valid && !cache_ready) begin
            tgt_d   = redir_tgt;
            fence_d = fence_i;
            state_d = S_DRAIN;
          end else if (fence_i) begin
            tgt_d   = redir_tgt;
            state_d = S_FLUSH;
          end else begin
            land     = 1'b1;
            land_tgt = redir_tgt;
          end
        end else if (cache_valid && cache_ready) begin
          fifo_push = 1'b1;
          pc_d      = pc_q + PC_INC;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          fifo_clear = 1'b1;
          tgt_d      = redir_tgt;
          fence_d    = fence_i;
        end
        if (cache_ready) begin
          if (redirect_valid ? fence_i : fence_q) begin
            state_d = S_FLUSH;
          end else begin
            land     = 1'b1;
            land_tgt = redirect_valid ? redir_tgt : tgt_q;
          end
        end
      end
      S_FLUSH, S_HALT: begin
        if (redirect_valid && fence_i) begin
          fifo_clear = 1'b1;
          tgt_d      = redir_tgt;
          state_d    = S_FLUSH;
        end else if (redirect_valid) begin
          fifo_clear = 1'b1;
          land       = 1'b1;
          land_tgt   = redir_tgt;
        end else if (state_q == S_FLUSH) begin
          land     = 1'b1;
          land_tgt = tgt_q;
        end
      end
    endcase

    if (land) begin
      if (TRAP_EN && misaligned(land_tgt[1:0])) begin
        fifo_push        = 1'b1;
        push_entry.pc    = land_tgt;
        push_entry.instr = '0;
        push_entry.err   = 1'b1;
        state_d          = S_HALT;
      end else begin
        pc_d    = land_tgt;
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      fence_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      fence_q <= fence_d;
    end
  end

  ifetch_fifo #(
    .DEPTH_LOG2(QDEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (fifo_clear),
    .push_i     (fifo_push),
    .push_data_i(push_entry),
    .pop_i      (fifo_pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus random traffic, checked against
// an expected instruction-stream scoreboard.
module tb_ifetch;

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk, rst;
  logic        redirect_valid, fence_i, cache_ready, out_ready;
  logic [31:0] redirect_pc, cache_rdata;
  logic        cache_valid, cache_flush, out_valid, out_err;
  logic [31:0] cache_addr, out_pc, out_instr;

  int    checks = 0;
  int    failures = 0;
  int    hs_count = 0;
  int    miss_left = 0;
  int    fetches;
  logic  mon_en = 1'b0;
  exp_t  exp_q[$];
  logic  exp_halt = 1'b0;
  logic [31:0] exp_next = 32'h0;

  ifetch #(
    .RESET_PC   (32'h0000_0100),
    .QDEPTH_LOG2(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fence_i       (fence_i),
    .cache_valid   (cache_valid),
    .cache_ready   (cache_ready),
    .cache_addr    (cache_addr),
    .cache_rdata   (cache_rdata),
    .cache_flush   (cache_flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_err       (out_err)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign cache_rdata = word_at(cache_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  // The architectural stream: sequential words from the last restart point.
  function automatic void refill();
    exp_t e;
    while (!exp_halt && exp_q.size() < 8) begin
      e.pc    = exp_next;
      e.instr = word_at(exp_next);
      e.err   = 1'b0;
      exp_q.push_back(e);
      exp_next = exp_next + 32'd4;
    end
  endfunction

  function automatic void restart_expect(input logic [31:0] tgt);
    exp_t e;
    exp_q.delete();
    if (TRAP_EN && tgt[1:0] != 2'b00) begin
      e.pc    = tgt;
      e.instr = 32'h0;
      e.err   = 1'b1;
      exp_q.push_back(e);
      exp_halt = 1'b1;
    end else begin
      exp_halt = 1'b0;
      exp_next = TRAP_EN ? tgt : {tgt[31:2], 2'b00};
      refill();
    end
  endfunction

  function automatic logic cache_model();
    if (!cache_valid) return logic'($urandom_range(0, 1));
    if (miss_left > 0) begin
      miss_left--;
      return 1'b0;
    end
    if ($urandom_range(0, 3) == 0) begin
      miss_left = int'($urandom_range(0, 4));
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // cr_mode: 0 = miss, 1 = hit, 2 = random cache behaviour
  task automatic step(input logic rv, input logic [31:0] rpc, input logic fi,
                      input int cr_mode, input logic ordy);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    fence_i        = fi;
    out_ready      = ordy;
    cache_ready    = (cr_mode == 2) ? cache_model() : logic'(cr_mode == 1);
    #3;
    if (rv) restart_expect(rpc);
  endtask

  task automatic do_reset(input logic ordy);
    @(negedge clk);
    mon_en         = 1'b0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    fence_i        = 1'b0;
    cache_ready    = 1'b1;
    out_ready      = ordy;
    #3;
    restart_expect(32'h100);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    #3;
    chk("rst_cache_valid", 32'(cache_valid), 32'd1);
    chk("rst_cache_flush", 32'(cache_flush), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_cache_addr", cache_addr, 32'h100);
  endtask

  // Monitor: scoreboard pops on every output handshake, plus request-hold checks.
  initial begin
    logic        prev_miss;
    logic [31:0] prev_addr;
    exp_t        e;
    prev_miss = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) begin
        prev_miss = 1'b0;
        continue;
      end
      if (prev_miss) begin
        chk("miss_hold_valid", 32'(cache_valid), 32'd1);
        chk("miss_hold_addr", cache_addr, prev_addr);
      end
      if (cache_flush) chk("flush_no_request", 32'(cache_valid), 32'd0);
      prev_miss = cache_valid && !cache_ready;
      prev_addr = cache_addr;
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got pc %h, required no output", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
          chk("out_err", 32'(out_err), 32'(e.err));
          refill();
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    logic        rv, fi, ordy;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    fence_i = 1'b0;
    cache_ready = 1'b1;
    out_ready = 1'b1;

    // Back-to-back hits stream out one instruction per cycle
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1, 1'b1);
      chk("seq_valid", 32'(out_valid), 32'd1);
      chk("seq_pc", out_pc, 32'h100 + 32'(4 * i));
    end

    // Backpressure fills the queue and stalls fetch
    do_reset(1'b0);
    fetches = int'(cache_valid && cache_ready);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 32'h0, 1'b0, 1, 1'b0);
      fetches += int'(cache_valid && cache_ready);
    end
    chk("fill_count", 32'(fetches), 32'd4);
    chk("full_stall", 32'(cache_valid), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("resume_valid", 32'(cache_valid), 32'd1);
    chk("resume_addr", cache_addr, 32'h110);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1, 1'b1);

    // Redirect during a held miss drains the old request
    step(1'b1, 32'h200, 1'b0, 1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 0, 1'b1);
    chk("miss_addr", cache_addr, 32'h200);
    step(1'b1, 32'h400, 1'b0, 0, 1'b1);
    chk("drain_addr", cache_addr, 32'h200);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 32'h0, 1'b0, 0, 1'b1);
      chk("drain_hold_addr", cache_addr, 32'h200);
      chk("drain_hold_valid", 32'(cache_valid), 32'd1);
    end
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("drain_done_addr", cache_addr, 32'h200);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("target_addr", cache_addr, 32'h400);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("target_out_valid", 32'(out_valid), 32'd1);
    chk("target_out_pc", out_pc, 32'h400);

    // Second redirect while draining replaces the first
    step(1'b0, 32'h0, 1'b0, 0, 1'b1);
    step(1'b1, 32'h500, 1'b0, 0, 1'b1);
    step(1'b1, 32'h600, 1'b0, 0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("last_wins_addr", cache_addr, 32'h600);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1, 1'b1);

    // fence.i with redirect: one flush cycle, then fetch at target
    step(1'b1, 32'h80, 1'b1, 1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("flush_pulse", 32'(cache_flush), 32'd1);
    chk("flush_valid", 32'(cache_valid), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("flush_end", 32'(cache_flush), 32'd0);
    chk("flush_resume_valid", 32'(cache_valid), 32'd1);
    chk("flush_resume_addr", cache_addr, 32'h80);
    step(1'b0, 32'h0, 1'b1, 1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("lone_fence_flush", 32'(cache_flush), 32'd0);
    chk("lone_fence_valid", 32'(cache_valid), 32'd1);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1, 1'b1);

    // Misaligned redirect target
    step(1'b1, 32'h102, 1'b0, 1, 1'b1);
`ifdef IFETCH_MISALIGN_TRAP_EN
    step(1'b0, 32'h0, 1'b0, 1, 1'b0);
    chk("trap_valid", 32'(out_valid), 32'd1);
    chk("trap_pc", out_pc, 32'h102);
    chk("trap_instr", out_instr, 32'h0);
    chk("trap_err", 32'(out_err), 32'd1);
    chk("trap_no_fetch", 32'(cache_valid), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1, 1'b1);
      chk("halt_no_fetch", 32'(cache_valid), 32'd0);
      chk("halt_no_out", 32'(out_valid), 32'd0);
    end
    step(1'b1, 32'h104, 1'b0, 1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("halt_exit_valid", 32'(cache_valid), 32'd1);
    chk("halt_exit_addr", cache_addr, 32'h104);
`else
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("align_addr", cache_addr, 32'h100);
    chk("align_valid", 32'(cache_valid), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("align_out_pc", out_pc, 32'h100);
    chk("align_out_err", 32'(out_err), 32'd0);
`endif
    repeat (4) step(1'b0, 32'h0, 1'b0, 1, 1'b1);

    // Reset while draining a fence redirect abandons the flush
    step(1'b0, 32'h0, 1'b0, 0, 1'b1);
    step(1'b1, 32'h300, 1'b1, 0, 1'b1);
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1, 1'b1);
      chk("post_rst_no_flush", 32'(cache_flush), 32'd0);
    end

    // Random traffic
    hs_count = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1'b1);
        continue;
      end
      rv = logic'($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0;
      else tgt = 32'($urandom_range(0, 4095)) << 2;
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      fi   = rv ? logic'($urandom_range(0, 3) == 0) : logic'($urandom_range(0, 19) == 0);
      ordy = logic'($urandom_range(0, 9) < 7);
      step(rv, tgt, fi, 2, ordy);
    end
    repeat (20) step(1'b0, 32'h0, 1'b0, 1, 1'b1);
    chk("random_progress", 32'(hs_count > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
